// File: rtl/plane_pkg.sv
// Shared definitions for the plane life controller: FSM state codes,
// sprite colours, keypad direction encodings and small decode helpers.
package plane_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_HIT    = 3'd2,
      ST_INVINC = 3'd3,
      ST_OVER   = 3'd4
   } state_e;

   localparam logic [11:0] RGB_PLAY   = 12'h8F0;
   localparam logic [11:0] RGB_INVINC = 12'h08F;
   localparam logic [11:0] RGB_HIT    = 12'hF00;
   localparam logic [11:0] RGB_OFF    = 12'h000;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   function automatic logic dir_is_one_hot(input logic [3:0] dir);
      return (dir == DIR_UP) || (dir == DIR_DOWN) ||
             (dir == DIR_LEFT) || (dir == DIR_RIGHT);
   endfunction

   // HIT blinks on bit 2 of the explosion timer.
   function automatic logic [11:0] rgb_for(input state_e st, input logic blink);
      case (st)
         ST_PLAY:   return RGB_PLAY;
         ST_INVINC: return RGB_INVINC;
         ST_HIT:    return blink ? RGB_HIT : RGB_OFF;
         default:   return RGB_OFF;
      endcase
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick down-counter: load has priority over tick, and the count
// saturates at zero. next_o exposes the value the register will take.
module frame_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       tick_i,
   output logic [7:0] value_o,
   output logic [7:0] next_o,
   output logic       zero_o
);

   logic [7:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load_i)
         value_d = load_val_i;
      else if (tick_i && (value_q != 8'd0))
         value_d = value_q - 8'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         value_q <= 8'd0;
      else
         value_q <= value_d;
   end

   assign value_o = value_q;
   assign next_o  = value_d;
   assign zero_o  = (value_q == 8'd0);

endmodule

// File: rtl/plane_life_ctrl.sv
// Plane life controller: tracks lives, explosion and invincibility phases,
// gates keypad direction and selects the plane sprite colour.
module plane_life_ctrl
   import plane_pkg::*;
#(
   parameter int LIVES_INIT = 3,
   parameter int HIT_FRAMES = 30,
   parameter int INV_FRAMES = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        boom,
   input  logic [3:0]  dir_in,
   output logic [3:0]  dir_out,
   output logic        respawn,
   output logic        invincible,
   output logic [1:0]  lives,
   output logic        game_over,
   output logic [2:0]  state,
   output logic [11:0] plane_rgb
);

   state_e      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic        respawn_q, respawn_d;
   logic [3:0]  dir_q;
   logic        inv_q, over_q;
   logic [11:0] rgb_q;

   logic        tmr_load, tmr_tick, tmr_zero, last_tick;
   logic [7:0]  tmr_load_val, tmr_value, tmr_next;

   frame_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .tick_i     (tmr_tick),
      .value_o    (tmr_value),
      .next_o     (tmr_next),
      .zero_o     (tmr_zero)
   );

   // This tick brings the timer to zero (or it already sits there).
   assign last_tick = frame_tick && (tmr_zero || (tmr_value == 8'd1));

   // NOTE: every signal driven here gets a default first, so no latches are inferred.
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      respawn_d    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = 8'd0;
      tmr_tick     = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d   = ST_PLAY;
               lives_d   = LIVES_INIT[1:0];
               tmr_load  = 1'b1;
               respawn_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (boom) begin
               state_d      = ST_HIT;
               lives_d      = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
               tmr_load     = 1'b1;
               tmr_load_val = HIT_FRAMES[7:0];
            end
         end
         ST_HIT: begin
            tmr_tick = frame_tick;
            if (last_tick) begin
               if (lives_q == 2'd0) begin
                  state_d = ST_OVER;
               end else begin
                  state_d      = ST_INVINC;
                  tmr_load     = 1'b1;
                  tmr_load_val = INV_FRAMES[7:0];
                  respawn_d    = 1'b1;
               end
            end
         end
         ST_INVINC: begin
            tmr_tick = frame_tick;
            if (last_tick)
               state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         lives_q   <= 2'd0;
         respawn_q <= 1'b0;
         dir_q     <= 4'd0;
         inv_q     <= 1'b0;
         over_q    <= 1'b0;
         rgb_q     <= RGB_OFF;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         respawn_q <= respawn_d;
         dir_q     <= (((state_d == ST_PLAY) || (state_d == ST_INVINC)) &&
                       dir_is_one_hot(dir_in)) ? dir_in : 4'd0;
         inv_q     <= (state_d == ST_INVINC);
         over_q    <= (state_d == ST_OVER);
         rgb_q     <= rgb_for(state_d, tmr_next[2]);
      end
   end

   assign state      = state_q;
   assign lives      = lives_q;
   assign respawn    = respawn_q;
   assign dir_out    = dir_q;
   assign invincible = inv_q;
   assign game_over  = over_q;
   assign plane_rgb  = rgb_q;

endmodule

// File: tb/tb_plane_life_ctrl.sv
// Directed bench for plane_life_ctrl with LIVES_INIT=2, HIT_FRAMES=2,
// INV_FRAMES=3; expected values are hand-computed per step.
module tb_plane_life_ctrl;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        start;
   logic        boom;
   logic [3:0]  dir_in;
   logic [3:0]  dir_out;
   logic        respawn;
   logic        invincible;
   logic [1:0]  lives;
   logic        game_over;
   logic [2:0]  state;
   logic [11:0] plane_rgb;

   int vectors    = 0;
   int miscompares = 0;

   plane_life_ctrl #(
      .LIVES_INIT (2),
      .HIT_FRAMES (2),
      .INV_FRAMES (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .start      (start),
      .boom       (boom),
      .dir_in     (dir_in),
      .dir_out    (dir_out),
      .respawn    (respawn),
      .invincible (invincible),
      .lives      (lives),
      .game_over  (game_over),
      .state      (state),
      .plane_rgb  (plane_rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      start      = 1'b0;
      boom       = 1'b0;
      dir_in     = 4'd0;

      // Reset state
      #3 rst = 1'b0;
      #1;
      check("rst_state", 16'(state), 16'd0);
      check("rst_lives", 16'(lives), 16'd0);
      check("rst_rgb", 16'(plane_rgb), 16'h000);
      check("rst_flags", {dir_out, respawn, invincible, game_over}, 16'd0);
      step();
      step();
      rst = 1'b1;
      step();
      check("idle_wait", 16'(state), 16'd0);

      // Start -> PLAY with a single respawn pulse
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_state", 16'(state), 16'd1);
      check("start_lives", 16'(lives), 16'd2);
      check("start_respawn", 16'(respawn), 16'd1);
      check("start_rgb", 16'(plane_rgb), 16'h8F0);
      step();
      check("respawn_once", 16'(respawn), 16'd0);

      // Direction gating
      dir_in = 4'b0001;
      step();
      check("dir_up", 16'(dir_out), 16'h1);
      dir_in = 4'b1100;
      step();
      check("dir_multi", 16'(dir_out), 16'h0);
      dir_in = 4'b0100;
      step();
      check("dir_left", 16'(dir_out), 16'h4);

      // First hit, boom held through HIT and INVINC
      boom = 1'b1;
      step();
      check("hit_state", 16'(state), 16'd2);
      check("hit_lives", 16'(lives), 16'd1);
      check("hit_dir", 16'(dir_out), 16'h0);
      check("hit_rgb", 16'(plane_rgb), 16'h000);
      tick();
      check("hit_after_1tick", 16'(state), 16'd2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("invinc_state", 16'(state), 16'd3);
      check("invinc_respawn", 16'(respawn), 16'd1);
      check("invinc_flag", 16'(invincible), 16'd1);
      check("invinc_rgb", 16'(plane_rgb), 16'h08F);
      check("invinc_dir", 16'(dir_out), 16'h4);
      step();
      check("invinc_respawn_end", 16'(respawn), 16'd0);
      check("invinc_boom_ignored", 16'(lives), 16'd1);
      tick();
      tick();
      check("invinc_after_2tick", 16'(state), 16'd3);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("back_to_play", 16'(state), 16'd1);
      check("back_lives", 16'(lives), 16'd1);

      // Second hit (boom still held) then game over
      step();
      boom = 1'b0;
      check("hit2_state", 16'(state), 16'd2);
      check("hit2_lives", 16'(lives), 16'd0);
      tick();
      tick();
      check("over_state", 16'(state), 16'd4);
      check("over_flag", 16'(game_over), 16'd1);
      check("over_lives", 16'(lives), 16'd0);
      check("over_rgb", 16'(plane_rgb), 16'h000);
      check("over_no_respawn", 16'(respawn), 16'd0);
      boom = 1'b1;
      step();
      boom = 1'b0;
      check("over_boom_ignored", 16'(state), 16'd4);

      // Restart from OVER
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_state", 16'(state), 16'd1);
      check("restart_lives", 16'(lives), 16'd2);
      check("restart_over_clr", 16'(game_over), 16'd0);
      check("restart_respawn", 16'(respawn), 16'd1);

      // Start ignored in PLAY
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("play_start_ignored", {14'd0, respawn, lives == 2'd2}, 16'd1);

      // boom + frame_tick in same clk: boom wins, timer loaded with 2
      boom       = 1'b1;
      frame_tick = 1'b1;
      step();
      boom       = 1'b0;
      frame_tick = 1'b0;
      check("prio_state", 16'(state), 16'd2);
      check("prio_lives", 16'(lives), 16'd1);
      tick();
      check("prio_timer_full", 16'(state), 16'd2);
      tick();
      check("prio_invinc", 16'(state), 16'd3);
      tick();

      // Reset mid-INVINC is immediate
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_state", 16'(state), 16'd0);
      check("midrst_lives", 16'(lives), 16'd0);
      check("midrst_rgb", 16'(plane_rgb), 16'h000);
      check("midrst_flags", {dir_out, respawn, invincible, game_over}, 16'd0);
      step();
      rst = 1'b1;
      step();
      step();
      check("midrst_idle", 16'(state), 16'd0);
      check("midrst_no_respawn", 16'(respawn), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
